clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It decodes three push-buttons (mode, up, down) into a set-mode state machine that selects hour, minute or second. It edits preset values, then drives the level-sensitive PE/preset inputs of the hour, minute and second counters. In RUN it is transparent and the counters free-run.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/key_debounce.sv | 28 ++
 rtl/clock_set_ctrl.sv | 70 +++++++
 tb/tb_clock_set_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, wrap moduli and field helpers for the digital clock
package clock_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam int HOUR_MOD = 24;
  localparam int MS_MOD   = 60;

  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] m, input logic inc);
    return inc ? ((v >= m - 8'd1) ? 8'd0 : v + 8'd1) : ((v == 8'd0) ? m - 8'd1 : v - 8'd1);
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] m);
    return (v >= m) ? 8'd0 : v;
  endfunction

  function automatic logic [2:0] sel_of(input state_t s);
    return (s == SET_HOUR) ? 3'b100 : (s == SET_MIN) ? 3'b010 : (s == SET_SEC) ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, steady-level debouncer and one-cycle press pulse
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  logic s1, s2, lvl;
  logic [19:0] cnt;
  // accept a new level after DEB_CYCLES equal samples; pulse only on the accepted rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= 20'd0;
      press <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      press <= s2 & ~lvl & (cnt == DEB_CYCLES - 20'd1);
      cnt   <= (s2 == lvl || cnt == DEB_CYCLES - 20'd1) ? 20'd0 : cnt + 20'd1;
      lvl   <= (s2 != lvl && cnt == DEB_CYCLES - 20'd1) ? s2 : lvl;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting FSM driving counter preset values and enables
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES     = 20'd1_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter int          HOUR_MOD       = clock_pkg::HOUR_MOD,
  parameter int          MS_MOD         = clock_pkg::MS_MOD
) (
  input  logic       clk,
  input  logic       _CR,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [7:0] show_hour,
  input  logic [7:0] show_min,
  input  logic [7:0] show_sec,
  output logic       PE_hour,
  output logic       PE_min,
  output logic       PE_sec,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic [2:0] set_sel
);
  localparam logic [7:0] HM = 8'(HOUR_MOD);
  localparam logic [7:0] MM = 8'(MS_MOD);
  state_t state, nxt;
  logic mode_p, up_p, down_p, inc, dec, tmo, pe;
  logic [31:0] tcnt;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk(clk), .rst_n(_CR), .key(key_mode), .press(mode_p));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up   (.clk(clk), .rst_n(_CR), .key(key_up),   .press(up_p));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (.clk(clk), .rst_n(_CR), .key(key_down), .press(down_p));

  // mode beats up/down; simultaneous up and down cancel
  assign inc = up_p & ~down_p & ~mode_p;
  assign dec = down_p & ~up_p & ~mode_p;
  assign tmo = (state != RUN) && (tcnt == TIMEOUT_CYCLES - 32'd1);
  assign nxt = mode_p ? ((state == SET_SEC) ? RUN : state_t'(state + 2'd1)) : RUN;
  assign PE_hour = pe;
  assign PE_min  = pe;
  assign PE_sec  = pe;

  // state walk, capture on leaving RUN, field edits and idle timeout
  always_ff @(posedge clk or negedge _CR) begin
    if (!_CR) begin
      state    <= RUN;
      pe       <= 1'b0;
      set_sel  <= 3'b000;
      pre_hour <= 8'd0;
      pre_min  <= 8'd0;
      pre_sec  <= 8'd0;
      tcnt     <= 32'd0;
    end else if (mode_p || tmo) begin
      state    <= nxt;
      pe       <= (nxt != RUN);
      set_sel  <= sel_of(nxt);
      tcnt     <= 32'd0;
      pre_hour <= (state == RUN) ? clamp(show_hour, HM) : pre_hour;
      pre_min  <= (state == RUN) ? clamp(show_min, MM) : pre_min;
      pre_sec  <= (state == RUN) ? clamp(show_sec, MM) : pre_sec;
    end else begin
      tcnt     <= (state == RUN || up_p || down_p) ? 32'd0 : tcnt + 32'd1;
      pre_hour <= (state == SET_HOUR && (inc || dec)) ? wrap_step(pre_hour, HM, inc) : pre_hour;
      pre_min  <= (state == SET_MIN && (inc || dec)) ? wrap_step(pre_min, MM, inc) : pre_min;
      pre_sec  <= (state == SET_SEC && (inc || dec)) ? wrap_step(pre_sec, MM, inc) : pre_sec;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for the time-setting controller
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic _CR = 1'b1;
  logic key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic [7:0] show_hour = 8'd0, show_min = 8'd0, show_sec = 8'd0;
  logic PE_hour, PE_min, PE_sec;
  logic [7:0] pre_hour, pre_min, pre_sec;
  logic [2:0] set_sel;
  logic [29:0] obs;
  logic [29:0] sb_q[$];
  int checks = 0, errors = 0;
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0;

  clock_set_ctrl #(.DEB_CYCLES(20'd4), .TIMEOUT_CYCLES(32'd50)) u_dut (
    .clk(clk), ._CR(_CR), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .show_hour(show_hour), .show_min(show_min), .show_sec(show_sec),
    .PE_hour(PE_hour), .PE_min(PE_min), .PE_sec(PE_sec),
    .pre_hour(pre_hour), .pre_min(pre_min), .pre_sec(pre_sec), .set_sel(set_sel)
  );

  always #5 clk = ~clk;
  assign obs = {PE_hour, PE_min, PE_sec, set_sel, pre_hour, pre_min, pre_sec};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] m_snap();
    logic pe;
    logic [2:0] sel;
    pe  = (m_st != 0);
    sel = (m_st == 1) ? 3'b100 : (m_st == 2) ? 3'b010 : (m_st == 3) ? 3'b001 : 3'b000;
    return {pe, pe, pe, sel, 8'(m_h), 8'(m_m), 8'(m_s)};
  endfunction

  task automatic sb_push();
    sb_q.push_back(m_snap());
  endtask

  task automatic sb_check(input string tag);
    chk(tag, {2'b00, obs}, {2'b00, sb_q.pop_front()});
  endtask

  task automatic m_mode();
    if (m_st == 0) begin
      m_st = 1;
      m_h = (int'(show_hour) < 24) ? int'(show_hour) : 0;
      m_m = (int'(show_min) < 60) ? int'(show_min) : 0;
      m_s = (int'(show_sec) < 60) ? int'(show_sec) : 0;
    end else m_st = (m_st + 1) % 4;
  endtask

  task automatic m_adj(input int d);
    if (m_st == 1) m_h = (m_h + 24 + d) % 24;
    else if (m_st == 2) m_m = (m_m + 60 + d) % 60;
    else if (m_st == 3) m_s = (m_s + 60 + d) % 60;
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    key_mode = m; key_up = u; key_down = d;
    repeat (10) @(posedge clk);
    #1 key_mode = 0; key_up = 0; key_down = 0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic enter_poll(input string tag);
    int n;
    n = 0;
    key_mode = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (set_sel == 3'b001) begin n = i; break; end
    end
    key_mode = 0;
    chk(tag, n, 7);
  endtask

  initial begin
    int n;
    show_hour = 8'd12; show_min = 8'd34; show_sec = 8'd56;
    #1 _CR = 0;
    repeat (2) @(posedge clk);
    #1;
    sb_push(); sb_check("reset");
    _CR = 1;
    repeat (2) @(posedge clk);
    #1;
    m_mode(); sb_push(); press(1, 0, 0); sb_check("enter_hour");
    m_adj(1); sb_push();
    n = 0;
    key_up = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (pre_hour != 8'd12) begin n = i; break; end
    end
    chk("up_latency", n, 7);
    repeat (4) @(posedge clk);
    #1 key_up = 0;
    repeat (8) @(posedge clk);
    #1 sb_check("held_up_once");
    sb_push();
    key_up = 1;
    repeat (3) @(posedge clk);
    #1 key_up = 0;
    repeat (10) @(posedge clk);
    #1 sb_check("short_up");
    for (int i = 0; i < 11; i++) begin
      m_adj(1); sb_push(); press(0, 1, 0); sb_check("hour_up");
    end
    m_mode(); sb_push(); press(1, 1, 0); sb_check("mode_beats_up");
    for (int i = 0; i < 26; i++) begin
      m_adj(1); sb_push(); press(0, 1, 0); sb_check("min_up");
    end
    m_adj(-1); sb_push(); press(0, 0, 1); sb_check("min_down_wrap");
    sb_push(); press(0, 1, 1); sb_check("up_down_drop");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("enter_sec");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("exit_run");
    show_hour = 8'd30; show_min = 8'd61; show_sec = 8'd59;
    m_mode(); sb_push(); press(1, 0, 0); sb_check("clamp");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("to_min");
    enter_poll("sec_entry");
    m_st = 0; sb_push();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (!PE_hour) begin n = i; break; end
    end
    chk("timeout_cycles", n, 50);
    sb_check("timeout_run");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("re_hour");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("re_min");
    enter_poll("sec_entry2");
    m_st = 3; m_adj(1); m_st = 0; sb_push();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i == 34) key_up = 1;
      if (i == 40) key_up = 0;
      if (!PE_hour) begin n = i; break; end
    end
    chk("timeout_restart", n, 91);
    sb_check("restart_run");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("rst_hour");
    m_mode(); sb_push(); press(1, 0, 0); sb_check("rst_min");
    #2 _CR = 0;
    #1;
    m_st = 0; m_h = 0; m_m = 0; m_s = 0;
    sb_push(); sb_check("async_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
